iic_eeprom_rd_seq: RTL and testbench
====================================

# iic_eeprom_rd_seq

Read-side sequencer for the I2C EEPROM at device address 7'b1010_000, driving the I2C master through `common_interface.master`. On `enable` it performs a random/sequential read: write-without-stop of one word-address byte, then a complete read of `rd_len` bytes. Each byte is delivered on a simple valid/ready output stream. It is the counterpart of the EEPROM byte-write sequencer and shares the same master port type.

## Interface
- `DEV_ADDR`, 7'b1010_000: 7-bit I2C device address driven on `cinf.addr`.
- `MAX_LEN`, 24'd256: largest accepted `rd_len`; larger values are clamped to `MAX_LEN`.
- `cinf.clock`  input  1  sole clock, taken from the interface.
- `cinf.rst_n`  input  1  synchronous, active-low reset, taken from the interface.
- `enable`  input  1  start request; sampled only in IDLE.
- `word_addr`  input  8  EEPROM start word address; latched on start.
- `rd_len`  input  24  bytes to read; latched on start.
- `out_ready`  input  1  downstream ready for `out_data`.
- `out_data`  output  8  read byte.
- `out_vld`  output  1  `out_data` valid.
- `out_last`  output  1  marks the final byte; qualified by `out_vld`.
- `busy`  output  1  high whenever state is not IDLE.
- `finish`  output  1  one-cycle pulse at the end of the sequence.
- `cinf`  modport master  —  drives `cmd`, `cmd_vld`, `addr`, `burst_len`, `wr_data`, `wr_vld`, `wr_last`, `rd_ready`; samples `cmd_ready`, `wr_ready`, `rd_data`, `rd_vld`, `rd_last`, `finish`.

## Operation
- Command codes:
  - IDLE = 0, WR_WNO_STOP = 2, COMPLETE_RD = 3.
  - `cinf.cmd` and `cinf.burst_len` are registered and change only on state entry.
- State machine:
  - **IDLE**: on `enable`, latch `word_addr` and `rd_len` (clamped), then go to SET_WCMD. If the latched length is 0, go to FSH instead.
  - **SET_WCMD**: `cmd`=2, `burst_len`=1, `cmd_vld`=1. On `cmd_vld & cmd_ready`, go to SET_WADDR.
  - **SET_WADDR**: `wr_data`=latched word address, `wr_vld`=1, `wr_last`=1. On `wr_vld & wr_ready`, go to WAIT_W.
  - **WAIT_W**: wait for `cinf.finish`, then go to SET_RCMD.
  - **SET_RCMD**: `cmd`=3, `burst_len`=latched length, `cmd_vld`=1. On handshake, go to RD_DATA.
  - **RD_DATA**:
    - `cinf.rd_ready` = `!out_vld | out_ready` (one-entry skid).
    - Each `rd_vld & rd_ready` loads `out_data` and increments the 24-bit beat counter.
    - The beat where counter == length-1 sets `out_last` and moves to WAIT_R.
  - **WAIT_R**: wait until `cinf.finish` has been seen and the output register has drained, then go to FSH.
  - **FSH**: pulse `finish` for one cycle, then go to IDLE.
- Valid signals are registered from next-state, so `cmd_vld`/`wr_vld` assert one cycle after state entry is decided.
- An early `cinf.rd_last` (before the counter reaches length-1) forces `out_last` on that byte. The counter stops there and the block goes to WAIT_R.
- `cinf.finish` pulses outside WAIT_W/WAIT_R are ignored.
- `enable` while `busy` is ignored; the request is not queued.

## Timing
- Reset values:
  - Outputs: `out_data`=0, `out_vld`=0, `out_last`=0, `busy`=0, `finish`=0.
  - Interface drives: `cmd`=0, `cmd_vld`=0, `wr_vld`=0, `wr_data`=0, `wr_last`=0, `rd_ready`=0, `burst_len`=0.
  - State: IDLE; counter=0.
- Sequence latency:
  - `enable` to `cmd_vld`: 2 cycles.
  - `rd_vld & rd_ready` beat to `out_vld`: 1 cycle.
  - `finish` pulse: ≥1 cycle after the last byte's `out_vld & out_ready`.
- Output stream:
  - `out_data`, `out_vld` and `out_last` are held stable while `out_vld & !out_ready`.
  - With `out_ready` held high, throughput is 1 byte/cycle.
- Simultaneous accept and refill: if `out_ready` and a new `rd_vld` beat arrive in the same cycle, the register reloads with no bubble.
- Reset asserted mid-sequence: all state returns to IDLE next edge and all valids drop. No `finish` is issued and the master is not cleaned up.
- Length 0: `finish` pulses 2 cycles after `enable`; no `cmd_vld` ever asserts.

## Configuration
- `EEPROM_RD_CHECK_EN`:
  - **Defined**: adds output `err` (1 bit, sticky until next start) and `err_cnt` (16 bits, saturating, cleared on start). Each delivered byte at offset k is compared against `(word_addr + k + 1) mod 256`, the pattern laid down by the byte-write sequencer. Each mismatch increments `err_cnt` and sets `err`.
  - **Undefined**: no compare logic; the `err`/`err_cnt` ports do not exist.

## Test plan
- Reset, then `enable` with `word_addr`=0x00, `rd_len`=8, master model returning 0x01..0x08 → `cmd` sequence 2 then 3, `burst_len` 1 then 8, `wr_data`=0x00. `out_data` = 0x01..0x08 with `out_last` on 0x08, then one `finish` pulse.
- `rd_len`=4, `out_ready` toggling 1/0 every cycle → all 4 bytes delivered in order, no loss or duplication, and `rd_ready` low while the output register is stalled.
- `rd_len`=0 → no `cmd_vld`; `finish` pulse 2 cycles after `enable`.
- `rd_len`=8, master asserts `rd_last` on byte 5 → `out_last` on byte 5, exactly 5 bytes out, then `finish`.
- `rst_n` low during RD_DATA after 3 bytes → all outputs at reset values next cycle. A new `enable` then runs a clean full sequence.
- With `EEPROM_RD_CHECK_EN`, `word_addr`=0x10 and byte 2 corrupted to 0xFF → `err`=1, `err_cnt`=1. All other bytes match 0x11, 0x12, ….

Source files
------------

// File: rtl/iic_eeprom_rd_seq_if.sv
// Shared I2C master command port: clock/reset plus command, write and read streams.
// The sequencer drives the master-side requests; the I2C master answers on the remaining signals.
interface common_interface;
  logic        clock;
  logic        rst_n;
  logic [1:0]  cmd;
  logic        cmd_vld;
  logic        cmd_ready;
  logic [6:0]  addr;
  logic [23:0] burst_len;
  logic [7:0]  wr_data;
  logic        wr_vld;
  logic        wr_ready;
  logic        wr_last;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic        rd_ready;
  logic        rd_last;
  logic        finish;

  modport master (
    input  clock, rst_n, cmd_ready, wr_ready, rd_data, rd_vld, rd_last, finish,
    output cmd, cmd_vld, addr, burst_len, wr_data, wr_vld, wr_last, rd_ready
  );
endinterface

// File: rtl/iic_eeprom_rd_seq.sv
// EEPROM random/sequential read sequencer: word-address write (no stop), then a burst read streamed out.
// Optional EEPROM_RD_CHECK_EN adds err/err_cnt checking bytes against the (word_addr + k + 1) write pattern.
module iic_eeprom_rd_seq #(
  parameter logic [6:0]  DEV_ADDR = 7'b1010_000,
  parameter logic [23:0] MAX_LEN  = 24'd256
) (
  common_interface.master cinf,
  input  logic        enable,
  input  logic [7:0]  word_addr,
  input  logic [23:0] rd_len,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_vld,
  output logic        out_last,
  output logic        busy,
  output logic        finish
`ifdef EEPROM_RD_CHECK_EN
  ,
  output logic        err,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [1:0] CMD_IDLE        = 2'd0;
  localparam logic [1:0] CMD_WR_WNO_STOP = 2'd2;
  localparam logic [1:0] CMD_COMPLETE_RD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SET_WCMD, S_SET_WADDR, S_WAIT_W, S_SET_RCMD, S_RD_DATA, S_WAIT_R, S_FSH
  } state_t;

  state_t      r_state, w_next;

  logic [1:0]  r_cmd, w_cmd_d;
  logic [23:0] r_burst, w_burst_d;
  logic        r_cmd_vld, w_cmd_vld_d;
  logic        r_wr_vld, w_wr_vld_d;
  logic [7:0]  r_wr_data, w_wr_data_d;
  logic        r_finish, w_finish_d;
  logic        w_entry;

  logic [7:0]  r_waddr;
  logic [23:0] r_len;
  logic [23:0] r_cnt;
  logic        r_fin_seen;
  logic [7:0]  r_out_data;
  logic        r_out_vld;
  logic        r_out_last;

  logic        w_start;
  logic [23:0] w_len;
  logic        w_cmd_hs;
  logic        w_wr_hs;
  logic        w_rd_ready;
  logic        w_beat;
  logic        w_cnt_last;
  logic        w_last_beat;
  logic        w_out_take;
  logic        w_fin_any;

  assign w_start     = (r_state == S_IDLE) && enable;
  assign w_len       = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
  assign w_cmd_hs    = r_cmd_vld && cinf.cmd_ready;
  assign w_wr_hs     = r_wr_vld && cinf.wr_ready;
  // One-entry skid: accept a new beat whenever the output register is empty or draining this cycle
  assign w_rd_ready  = (r_state == S_RD_DATA) && (!r_out_vld || out_ready);
  assign w_beat      = cinf.rd_vld && w_rd_ready;
  assign w_cnt_last  = (r_cnt == (r_len - 24'd1));
  assign w_last_beat = w_beat && (w_cnt_last || cinf.rd_last);
  assign w_out_take  = r_out_vld && out_ready;
  assign w_fin_any   = r_fin_seen || cinf.finish;

  always_ff @(posedge cinf.clock) begin
    if (!cinf.rst_n) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (enable) w_next = (w_len == 24'd0) ? S_FSH : S_SET_WCMD;
      S_SET_WCMD:  if (w_cmd_hs) w_next = S_SET_WADDR;
      S_SET_WADDR: if (w_wr_hs) w_next = S_WAIT_W;
      S_WAIT_W:    if (cinf.finish) w_next = S_SET_RCMD;
      S_SET_RCMD:  if (w_cmd_hs) w_next = S_RD_DATA;
      S_RD_DATA:   if (w_last_beat) w_next = S_WAIT_R;
      S_WAIT_R:    if (w_fin_any && !r_out_vld) w_next = S_FSH;
      S_FSH:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Command fields load on state entry; valids rise one cycle after entry and drop on handshake
  always_comb begin
    w_entry     = (w_next != r_state);
    w_cmd_d     = r_cmd;
    w_burst_d   = r_burst;
    w_wr_data_d = r_wr_data;
    if (w_entry) begin
      case (w_next)
        S_SET_WCMD: begin
          w_cmd_d   = CMD_WR_WNO_STOP;
          w_burst_d = 24'd1;
        end
        S_SET_WADDR: w_wr_data_d = r_waddr;
        S_SET_RCMD: begin
          w_cmd_d   = CMD_COMPLETE_RD;
          w_burst_d = r_len;
        end
        S_IDLE: begin
          w_cmd_d   = CMD_IDLE;
          w_burst_d = '0;
        end
        default: begin end
      endcase
    end
    w_cmd_vld_d = !w_entry && ((r_state == S_SET_WCMD) || (r_state == S_SET_RCMD));
    w_wr_vld_d  = !w_entry && (r_state == S_SET_WADDR);
    w_finish_d  = (r_state == S_FSH);
  end

  always_ff @(posedge cinf.clock) begin
    if (!cinf.rst_n) begin
      r_cmd      <= CMD_IDLE;
      r_burst    <= '0;
      r_cmd_vld  <= 1'b0;
      r_wr_vld   <= 1'b0;
      r_wr_data  <= '0;
      r_finish   <= 1'b0;
      r_waddr    <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_fin_seen <= 1'b0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end else begin
      r_cmd     <= w_cmd_d;
      r_burst   <= w_burst_d;
      r_cmd_vld <= w_cmd_vld_d;
      r_wr_vld  <= w_wr_vld_d;
      r_wr_data <= w_wr_data_d;
      r_finish  <= w_finish_d;
      if (w_start) begin
        r_waddr    <= word_addr;
        r_len      <= w_len;
        r_cnt      <= '0;
        r_fin_seen <= 1'b0;
      end else if ((r_state == S_WAIT_R) && cinf.finish) begin
        r_fin_seen <= 1'b1;
      end
      if (w_beat) begin
        r_out_data <= cinf.rd_data;
        r_out_vld  <= 1'b1;
        r_out_last <= w_cnt_last || cinf.rd_last;
        r_cnt      <= r_cnt + 24'd1;
      end else if (w_out_take) begin
        r_out_vld  <= 1'b0;
        r_out_last <= 1'b0;
      end
    end
  end

`ifdef EEPROM_RD_CHECK_EN
  logic        r_err;
  logic [15:0] r_err_cnt;
  logic [7:0]  w_exp_byte;

  assign w_exp_byte = r_waddr + r_cnt[7:0] + 8'd1;

  always_ff @(posedge cinf.clock) begin
    if (!cinf.rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_start) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_beat && (cinf.rd_data != w_exp_byte)) begin
      r_err <= 1'b1;
      if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`endif

  assign cinf.cmd       = r_cmd;
  assign cinf.cmd_vld   = r_cmd_vld;
  assign cinf.addr      = DEV_ADDR;
  assign cinf.burst_len = r_burst;
  assign cinf.wr_data   = r_wr_data;
  assign cinf.wr_vld    = r_wr_vld;
  assign cinf.wr_last   = r_wr_vld;
  assign cinf.rd_ready  = w_rd_ready;

  assign out_data = r_out_data;
  assign out_vld  = r_out_vld;
  assign out_last = r_out_last;
  assign busy     = (r_state != S_IDLE);
  assign finish   = r_finish;

endmodule

// File: tb/tb_iic_eeprom_rd_seq.sv
// Bench for iic_eeprom_rd_seq: I2C master model plus command/write/read-byte scoreboards.
module tb_iic_eeprom_rd_seq;

  common_interface cinf ();

  logic        enable;
  logic [7:0]  word_addr;
  logic [23:0] rd_len;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_last;
  logic        busy;
  logic        fin_o;
`ifdef EEPROM_RD_CHECK_EN
  logic        err;
  logic [15:0] err_cnt;
`endif

  iic_eeprom_rd_seq dut (
    .cinf      (cinf.master),
    .enable    (enable),
    .word_addr (word_addr),
    .rd_len    (rd_len),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_vld   (out_vld),
    .out_last  (out_last),
    .busy      (busy),
    .finish    (fin_o)
`ifdef EEPROM_RD_CHECK_EN
    ,
    .err       (err),
    .err_cnt   (err_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [25:0] cmd_q[$];
  logic [8:0]  wr_q[$];
  logic [8:0]  out_q[$];

  int out_cnt    = 0;
  int fin_cnt    = 0;
  int cmdvld_cnt = 0;
  logic fin_prev = 1'b0;

  int ready_mode  = 0;
  int early_idx   = -1;
  int corrupt_idx = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] base, input int k);
    return base + 8'(k) + 8'd1;
  endfunction

  initial begin
    cinf.clock = 1'b0;
    forever #5 cinf.clock = ~cinf.clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // I2C master model: samples on negedge, answers just after the following posedge
  initial begin : master
    logic        s_rst, s_cmd_hs, s_wr_hs, s_rd_hs;
    logic [1:0]  s_cmd;
    logic [23:0] s_burst;
    logic [7:0]  s_wdata;
    logic [7:0]  m_base;
    int          m_idx, m_total, m_fin_dly;
    m_base = 8'h00; m_idx = 0; m_total = 0; m_fin_dly = 0;
    cinf.cmd_ready = 1'b1;
    cinf.wr_ready  = 1'b1;
    cinf.rd_vld    = 1'b0;
    cinf.rd_last   = 1'b0;
    cinf.rd_data   = 8'h00;
    cinf.finish    = 1'b0;
    out_ready      = 1'b1;
    forever begin
      @(negedge cinf.clock);
      s_rst    = cinf.rst_n;
      s_cmd_hs = cinf.cmd_vld && cinf.cmd_ready;
      s_cmd    = cinf.cmd;
      s_burst  = cinf.burst_len;
      s_wr_hs  = cinf.wr_vld && cinf.wr_ready;
      s_wdata  = cinf.wr_data;
      s_rd_hs  = cinf.rd_vld && cinf.rd_ready;
      @(posedge cinf.clock);
      #1;
      cinf.finish = 1'b0;
      out_ready   = (ready_mode == 1) ? !out_ready : 1'b1;
      if (!s_rst) begin
        m_fin_dly    = 0;
        cinf.rd_vld  = 1'b0;
        cinf.rd_last = 1'b0;
      end else begin
        if (m_fin_dly > 0) begin
          m_fin_dly--;
          if (m_fin_dly == 0) cinf.finish = 1'b1;
        end
        if (s_wr_hs) begin
          m_base    = s_wdata;
          m_fin_dly = 2;
        end
        if (s_cmd_hs && (s_cmd == 2'd3)) begin
          m_idx   = 0;
          m_total = int'(s_burst);
        end else if (s_rd_hs) begin
          if (cinf.rd_last) begin
            cinf.rd_vld  = 1'b0;
            cinf.rd_last = 1'b0;
            m_fin_dly    = 2;
          end else begin
            m_idx++;
          end
        end
        if ((s_cmd_hs && (s_cmd == 2'd3)) || (s_rd_hs && cinf.rd_vld)) begin
          cinf.rd_vld  = 1'b1;
          cinf.rd_data = (m_idx == corrupt_idx) ? 8'hFF : pat(m_base, m_idx);
          cinf.rd_last = (m_idx == m_total - 1) || (m_idx == early_idx);
        end
      end
    end
  end

  // Monitor: pops scoreboards on each handshake and watches the skid stall
  initial begin : monitor
    logic [25:0] e_cmd;
    logic [8:0]  e_b;
    forever begin
      @(negedge cinf.clock);
      if (cinf.cmd_vld) cmdvld_cnt++;
      if (cinf.cmd_vld && cinf.cmd_ready) begin
        chk("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
        chk("dev_addr", 32'(cinf.addr), 32'h50);
        if (cmd_q.size() != 0) begin
          e_cmd = cmd_q.pop_front();
          chk("cmd_burst", 32'({cinf.cmd, cinf.burst_len}), 32'(e_cmd));
        end
      end
      if (cinf.wr_vld && cinf.wr_ready) begin
        chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          e_b = wr_q.pop_front();
          chk("wr_last_data", 32'({cinf.wr_last, cinf.wr_data}), 32'(e_b));
        end
      end
      if (out_vld && out_ready) begin
        out_cnt++;
        chk("out_expected", 32'(out_q.size() != 0), 32'd1);
        if (out_q.size() != 0) begin
          e_b = out_q.pop_front();
          chk("out_last_data", 32'({out_last, out_data}), 32'(e_b));
        end
      end
      if (cinf.rst_n && out_vld && !out_ready) chk("rd_ready_stall", 32'(cinf.rd_ready), 32'd0);
      if (fin_o && !fin_prev) fin_cnt++;
      fin_prev = fin_o;
    end
  end

  task automatic push_seq(input logic [7:0] wa, input int len_eff, input int early, input int corrupt);
    int n;
    cmd_q.push_back({2'd2, 24'd1});
    wr_q.push_back({1'b1, wa});
    cmd_q.push_back({2'd3, 24'(len_eff)});
    n = (early >= 0) ? early + 1 : len_eff;
    for (int k = 0; k < n; k++)
      out_q.push_back({(k == n - 1), (k == corrupt) ? 8'hFF : pat(wa, k)});
  endtask

  task automatic start(input logic [7:0] wa, input logic [23:0] len);
    @(posedge cinf.clock);
    #1;
    enable    = 1'b1;
    word_addr = wa;
    rd_len    = len;
    @(posedge cinf.clock);
    #1;
    enable = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int f0, n;
    f0 = fin_cnt;
    n  = 0;
    @(negedge cinf.clock);
    while (!fin_o && n < budget) begin
      @(negedge cinf.clock);
      n++;
    end
    chk({tag, "_finish_seen"}, 32'(fin_o), 32'd1);
    @(negedge cinf.clock);
    chk({tag, "_finish_width"}, 32'(fin_o), 32'd0);
    chk({tag, "_finish_count"}, 32'(fin_cnt - f0), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_out_q_empty"}, 32'(out_q.size()), 32'd0);
    chk({tag, "_cmd_q_empty"}, 32'(cmd_q.size()), 32'd0);
  endtask

  initial begin : main
    int o0, f0, c0, n;
    cinf.rst_n = 1'b0;
    enable     = 1'b0;
    word_addr  = 8'h00;
    rd_len     = 24'd0;
    repeat (3) @(posedge cinf.clock);
    @(negedge cinf.clock);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(fin_o), 32'd0);
    chk("rst_cmd", 32'(cinf.cmd), 32'd0);
    chk("rst_cmd_vld", 32'(cinf.cmd_vld), 32'd0);
    chk("rst_wr_vld", 32'(cinf.wr_vld), 32'd0);
    chk("rst_wr_data", 32'(cinf.wr_data), 32'd0);
    chk("rst_wr_last", 32'(cinf.wr_last), 32'd0);
    chk("rst_rd_ready", 32'(cinf.rd_ready), 32'd0);
    chk("rst_burst_len", 32'(cinf.burst_len), 32'd0);
    @(posedge cinf.clock);
    #1;
    cinf.rst_n = 1'b1;

    // Basic 8-byte read from address 0
    o0 = out_cnt;
    push_seq(8'h00, 8, -1, -1);
    start(8'h00, 24'd8);
    @(negedge cinf.clock);
    chk("en2cmd_c1", 32'(cinf.cmd_vld), 32'd0);
    @(negedge cinf.clock);
    chk("en2cmd_c2", 32'(cinf.cmd_vld), 32'd1);
    wait_done("basic", 200);
    chk("basic_count", 32'(out_cnt - o0), 32'd8);

    // Toggling out_ready, plus an enable pulse while busy that must be dropped
    ready_mode = 1;
    o0 = out_cnt;
    push_seq(8'h30, 4, -1, -1);
    start(8'h30, 24'd4);
    repeat (2) @(posedge cinf.clock);
    #1;
    enable    = 1'b1;
    word_addr = 8'h99;
    rd_len    = 24'd2;
    @(posedge cinf.clock);
    #1;
    enable = 1'b0;
    wait_done("toggle", 200);
    ready_mode = 0;
    f0 = fin_cnt;
    repeat (10) @(negedge cinf.clock);
    chk("toggle_count", 32'(out_cnt - o0), 32'd4);
    chk("busy_enable_dropped", 32'(fin_cnt - f0), 32'd0);

    // Zero length: finish 2 cycles after enable, no command
    c0 = cmdvld_cnt;
    start(8'h40, 24'd0);
    @(negedge cinf.clock);
    chk("len0_busy_c1", 32'(busy), 32'd1);
    chk("len0_finish_c1", 32'(fin_o), 32'd0);
    @(negedge cinf.clock);
    chk("len0_finish_c2", 32'(fin_o), 32'd1);
    repeat (5) @(negedge cinf.clock);
    chk("len0_no_cmd_vld", 32'(cmdvld_cnt - c0), 32'd0);

    // Early rd_last on byte 5 of 8
    early_idx = 4;
    o0 = out_cnt;
    push_seq(8'h50, 8, 4, -1);
    start(8'h50, 24'd8);
    wait_done("early", 200);
    chk("early_count", 32'(out_cnt - o0), 32'd5);
    early_idx = -1;

    // Oversized request clamps to MAX_LEN and wraps the byte pattern
    o0 = out_cnt;
    push_seq(8'hF0, 256, -1, -1);
    start(8'hF0, 24'd300);
    wait_done("clamp", 600);
    chk("clamp_count", 32'(out_cnt - o0), 32'd256);

    // Reset in the middle of the data phase
    o0 = out_cnt;
    f0 = fin_cnt;
    push_seq(8'h60, 8, -1, -1);
    start(8'h60, 24'd8);
    n = 0;
    while ((out_cnt - o0) < 3 && n < 100) begin
      @(negedge cinf.clock);
      n++;
    end
    chk("midrst_reached_3", 32'((out_cnt - o0) >= 3), 32'd1);
    @(posedge cinf.clock);
    #1;
    cinf.rst_n = 1'b0;
    @(posedge cinf.clock);
    #1;
    chk("midrst_out_vld", 32'(out_vld), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_ready", 32'(cinf.rd_ready), 32'd0);
    chk("midrst_cmd_vld", 32'(cinf.cmd_vld), 32'd0);
    chk("midrst_cmd", 32'(cinf.cmd), 32'd0);
    cinf.rst_n = 1'b1;
    out_q.delete();
    cmd_q.delete();
    wr_q.delete();
    repeat (8) @(negedge cinf.clock);
    chk("midrst_no_finish", 32'(fin_cnt - f0), 32'd0);
    o0 = out_cnt;
    push_seq(8'h70, 8, -1, -1);
    start(8'h70, 24'd8);
    wait_done("after_rst", 200);
    chk("after_rst_count", 32'(out_cnt - o0), 32'd8);

`ifdef EEPROM_RD_CHECK_EN
    chk("chk_clean_err", 32'(err), 32'd0);
    chk("chk_clean_cnt", 32'(err_cnt), 32'd0);
    corrupt_idx = 1;
    push_seq(8'h10, 4, -1, 1);
    start(8'h10, 24'd4);
    wait_done("chk", 200);
    chk("chk_err", 32'(err), 32'd1);
    chk("chk_err_cnt", 32'(err_cnt), 32'd1);
    corrupt_idx = -1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
